// File: rtl/alu_issue_pkg.sv
// Shared datapath definitions for the issue stage and the ALU it feeds.
package alu_issue_pkg;
    localparam int WORD = 16;
    localparam int OPW  = 5;
    localparam int REGW = 4;
    localparam int NREG = 16;

    localparam logic [OPW-1:0] OP_ADD = 5'd0;
    localparam logic [OPW-1:0] OP_SUB = 5'd1;
    localparam logic [OPW-1:0] OP_AND = 5'd2;
    localparam logic [OPW-1:0] OP_OR  = 5'd3;
    localparam logic [OPW-1:0] OP_XOR = 5'd4;
endpackage

// File: rtl/alu_issue_regfile.sv
// Register file: one synchronous write port, two async read ports plus a debug port; r0 reads zero.
module alu_issue_regfile
    import alu_issue_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [REGW-1:0] waddr,
    input  logic [WORD-1:0] wdata,
    input  logic [REGW-1:0] raddr_a,
    output logic [WORD-1:0] rdata_a,
    input  logic [REGW-1:0] raddr_b,
    output logic [WORD-1:0] rdata_b,
    input  logic [REGW-1:0] dbg_addr,
    output logic [WORD-1:0] dbg_data
);
    logic [WORD-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = (raddr_a  == '0) ? '0 : regs[raddr_a];
    assign rdata_b  = (raddr_b  == '0) ? '0 : regs[raddr_b];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage: reads/forwards operands into the execute register feeding the ALU,
// and writes the ALU result back at the end of the execute cycle.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_op,
    input  logic [REGW-1:0] in_rd,
    input  logic [REGW-1:0] in_rs,
    input  logic [REGW-1:0] in_rt,
    input  logic            in_imm_sel,
    input  logic [WORD-1:0] in_imm,
    input  logic            hold,
    output logic [WORD-1:0] X,
    output logic [WORD-1:0] Y,
    output logic [OPW-1:0]  ALUop,
    output logic            ex_valid,
    input  logic [WORD-1:0] z,
    input  logic [REGW-1:0] dbg_addr,
    output logic [WORD-1:0] dbg_data
);
    logic [REGW-1:0] ex_rd;
    logic [WORD-1:0] rf_a, rf_b;
    logic [WORD-1:0] opnd_x, opnd_y;
    logic            wb_en;

    assign in_ready = !hold;
    assign wb_en    = ex_valid && !hold;

    alu_issue_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wb_en),
        .waddr    (ex_rd),
        .wdata    (z),
        .raddr_a  (in_rs),
        .rdata_a  (rf_a),
        .raddr_b  (in_rt),
        .rdata_b  (rf_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // The retiring result is forwarded so a dependent instruction never sees the stale entry.
    always_comb begin
        opnd_x = rf_a;
        opnd_y = rf_b;
        if (in_rs == '0)
            opnd_x = '0;
        else if (wb_en && ex_rd == in_rs)
            opnd_x = z;
        if (in_imm_sel)
            opnd_y = in_imm;
        else if (in_rt == '0)
            opnd_y = '0;
        else if (wb_en && ex_rd == in_rt)
            opnd_y = z;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            X        <= '0;
            Y        <= '0;
            ALUop    <= '0;
            ex_rd    <= '0;
            ex_valid <= 1'b0;
        end else if (!hold) begin
            if (in_valid) begin
                X        <= opnd_x;
                Y        <= opnd_y;
                ALUop    <= in_op;
                ex_rd    <= in_rd;
                ex_valid <= 1'b1;
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-issue stage that sits directly upstream of the combinational `alu` and drives its `X`, `Y` and `ALUop` inputs. It accepts one instruction per cycle over a valid/ready handshake and reads operands from a 16-entry register file, with same-cycle forwarding of the in-flight ALU result. The ALU result `z` is written back into the register file at the end of the execute cycle. Together with `alu`, this block forms a two-stage datapath: issue, then execute/writeback.

## Interface
- `NREG`, 16: register-file entries; the index width is log2(`NREG`) = 4.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: instruction offered.
- `in_ready`  out  1: the stage can accept; equals `!hold`, combinational.
- `in_op`  in  5: ALU opcode, passed through unmodified.
- `in_rd`, `in_rs`, `in_rt`  in  4 each: destination register, X-source register and Y-source register.
- `in_imm_sel`  in  1: 1 = Y comes from `in_imm` instead of `in_rt`.
- `in_imm`  in  `WORD`: immediate operand.
- `hold`  in  1: downstream stall; freezes the execute register.
- `X`, `Y`  out  `WORD`: registered operands to `alu`.
- `ALUop`  out  5: registered opcode to `alu`.
- `ex_valid`  out  1: `X`/`Y`/`ALUop` hold a live instruction.
- `z`  in  `WORD`: combinational result from `alu`.
- `dbg_addr`  in  4, `dbg_data`  out  `WORD`: asynchronous register-file read port for the bench.

## Operation
- Execute register: `X`, `Y`, `ALUop`, `ex_rd` (internal), `ex_valid`.
- Accept condition: `in_valid && in_ready`. On accept:
  - `X` = operand(`in_rs`).
  - `Y` = `in_imm_sel` ? `in_imm` : operand(`in_rt`).
  - `ALUop` = `in_op`; `ex_rd` = `in_rd`; `ex_valid` = 1.
- Operand(r):
  - 0 if r == 0. Register 0 reads as zero and ignores writes.
  - Otherwise `z` if `ex_valid && !hold && ex_rd == r` (forwarding).
  - Otherwise `regs[r]`.
- Writeback: on every edge with `ex_valid && !hold && ex_rd != 0`, `regs[ex_rd]` <= `z`.
- Edge with `!hold && !in_valid`: `ex_valid` <= 0. `X`, `Y` and `ALUop` keep their values, because they are don't-care while `ex_valid` is low.
- `hold` = 1: the execute register and the register file do not change. No writeback happens, so a held instruction writes exactly once, on the first edge with `hold` = 0.
- Simultaneous writeback and accept, where the new instruction reads `ex_rd`: the forwarded `z` is used, never the stale `regs` value.
- Operand widths are all `WORD`. No arithmetic is performed here; the opcode is never decoded.

## Timing
- Reset (async assert, sync release on `clk`): `regs[*]` = 0, `X` = 0, `Y` = 0, `ALUop` = 0, `ex_valid` = 0, `ex_rd` = 0. `in_ready` follows `hold` even during reset.
- Latency: an instruction accepted at edge N presents operands after edge N. `z` is valid in cycle N+1 and is written at edge N+1 (if not held).
- Throughput: one instruction per cycle. Back-to-back dependent instructions issue without bubbles.
- Reset asserted mid-operation discards the in-flight instruction; its result is never written.
- `dbg_data` = `regs[dbg_addr]`, combinational. It reflects writes after the writing edge and reads 0 for address 0.

## Structure
- `WORD` (16-bit) and the 5-bit opcode width/constants live in the shared definitions header already used by `alu`. This block adds `REGW` = 4 to it.
- One sub-module is natural: `regfile` (`NREG` x `WORD`, one synchronous write port, two asynchronous read ports plus the debug port, r0 hardwired to zero). Forwarding muxes and the execute register stay in `alu_issue`.
- The bench instantiates `alu_issue` driving the real `alu`, with `z` fed back.

## Test plan
- Reset: assert `rst_n` = 0 mid-run → `ex_valid` = 0, `X` = `Y` = 0, and `dbg_data` = 0 for all 16 addresses.
- Immediate load: issue ADD rd=1, rs=0, imm=16'h0005 → `X` = 0 and `Y` = 5 next cycle; the cycle after that, `dbg_addr`=1 gives 16'h0005.
- Forwarding: back-to-back ADD r1 = r0 + 3, then ADD r2 = r1 + r1 → the second instruction shows `X` = `Y` = 3 with no stall, and r2 ends at 6.
- Hold: stall with `hold` = 1 for 3 cycles during ADD r3 = r0 + 7 → `in_ready` = 0, `X`/`Y`/`ALUop` stable, r3 stays 0 until the hold releases, then becomes 7 exactly once.
- r0 protection: ADD rd=0, imm=16'hFFFF, followed immediately by a read of r0 → `X` = 0 (no forward), and `dbg_data`(0) = 0.
- Bubble: `in_valid` = 0 for one cycle between instructions → `ex_valid` drops for exactly one cycle and no spurious register write occurs.
